// File: rtl/hetic_nest_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hetic_nest_ctrl_pkg : shared types for the HETI nesting controller
// Rev 1.0
// ============================================================================
package hetic_nest_ctrl_pkg;

  localparam int unsigned NrIrqLinesDef = 64;
  localparam int unsigned NrIrqPriosDef = 32;
  localparam int unsigned StackDepthDef = 8;
  localparam int unsigned PkgPrioWidth  = $clog2(NrIrqPriosDef);

  // One level-stack frame: the threshold and nest flag of the preempted context.
  typedef struct packed {
    logic [PkgPrioWidth-1:0] level;
    logic                    nest;
  } nest_entry_t;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    REQ = 1'b1
  } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/hetic_nest_ctrl_if.sv
`default_nettype none
// ============================================================================
// hetic_nest_ctrl_if : controller-side claim bus and core-side trap handshake
// Rev 1.0
// ============================================================================
interface hetic_nest_ctrl_if
  import hetic_nest_ctrl_pkg::*;
#(
  parameter int unsigned IrqWidth  = $clog2(NrIrqLinesDef),
  parameter int unsigned PrioWidth = PkgPrioWidth
);
  logic                 irq_valid_i;
  logic [IrqWidth-1:0]  irq_id_i;
  logic [PrioWidth-1:0] irq_level_i;
  logic                 irq_heti_i;
  logic                 irq_nest_i;
  logic                 irq_ack_o;
  logic [IrqWidth-1:0]  irq_ack_id_o;
  logic                 core_irq_req_o;
  logic [IrqWidth-1:0]  core_irq_id_o;
  logic                 core_irq_heti_o;
  logic                 core_irq_ack_i;
  logic                 core_mret_i;

  modport slave (
    input  irq_valid_i, irq_id_i, irq_level_i, irq_heti_i, irq_nest_i,
    input  core_irq_ack_i, core_mret_i,
    output irq_ack_o, irq_ack_id_o, core_irq_req_o, core_irq_id_o, core_irq_heti_o
  );

  modport master (
    output irq_valid_i, irq_id_i, irq_level_i, irq_heti_i, irq_nest_i,
    output core_irq_ack_i, core_mret_i,
    input  irq_ack_o, irq_ack_id_o, core_irq_req_o, core_irq_id_o, core_irq_heti_o
  );
endinterface
`default_nettype wire

// File: rtl/hetic_nest_ctrl_level_stack.sv
`default_nettype none
// ============================================================================
// hetic_level_stack : LIFO of preempted contexts; push+pop rewrites the top
// Rev 1.0
// ============================================================================
module hetic_level_stack #(
  parameter  int unsigned StackDepth = 8,
  parameter  type         entry_t    = logic,
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1),
  localparam int unsigned IdxWidth   = (StackDepth > 1) ? $clog2(StackDepth) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  entry_t                data_i,
  output entry_t                top_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DepthWidth-1:0] depth_o
);

  entry_t                mem_q [StackDepth];
  logic [DepthWidth-1:0] depth_q;
  logic [IdxWidth-1:0]   top_idx;
  logic [IdxWidth-1:0]   wr_idx;
  logic                  do_pop;
  logic                  do_push;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DepthWidth'(StackDepth));
  assign top_idx = IdxWidth'(depth_q - DepthWidth'(1));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_idx  = do_pop ? top_idx : IdxWidth'(depth_q);
  assign top_o   = empty_o ? '0 : mem_q[top_idx];
  assign depth_o = depth_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      for (int i = 0; i < int'(StackDepth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_idx] <= data_i;
      end
      if (do_push && !do_pop) begin
        depth_q <= depth_q + DepthWidth'(1);
      end else if (do_pop && !do_push) begin
        depth_q <= depth_q - DepthWidth'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hetic_nest_ctrl.sv
`default_nettype none
// ============================================================================
// hetic_nest_ctrl : preemption gate and trap handshake behind the HETI arbiter
// Rev 1.0
// ============================================================================
module hetic_nest_ctrl
  import hetic_nest_ctrl_pkg::*;
#(
  parameter  int unsigned NrIrqLines = NrIrqLinesDef,
  parameter  int unsigned NrIrqPrios = NrIrqPriosDef,
  parameter  int unsigned StackDepth = StackDepthDef,
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines),
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios),
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  hetic_nest_ctrl_if.slave       ctrl_if,
  output logic [PrioWidth-1:0]   level_o,
  output logic [DepthWidth-1:0]  depth_o,
  output logic                   err_o
);

  fsm_state_e           state_q, state_d;
  logic [IrqWidth-1:0]  lat_id_q, lat_id_d;
  logic [PrioWidth-1:0] lat_level_q, lat_level_d;
  logic                 lat_heti_q, lat_heti_d;
  logic                 lat_nest_q, lat_nest_d;
  logic [PrioWidth-1:0] level_q, level_d;
  logic                 nest_q, nest_d;
  logic                 ack_q, ack_d;
  logic [IrqWidth-1:0]  ack_id_q, ack_id_d;
  logic                 err_q, err_d;

  logic        eligible;
  logic        push, pop, full, empty;
  nest_entry_t push_data, top;

  hetic_level_stack #(
    .StackDepth (StackDepth),
    .entry_t    (nest_entry_t)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .top_o   (top),
    .full_o  (full),
    .empty_o (empty),
    .depth_o (depth_o)
  );

  assign eligible = ctrl_if.irq_valid_i && (ctrl_if.irq_level_i > level_q) && !full;
  assign pop      = ctrl_if.core_mret_i && !empty;
  // With a simultaneous mret the popped frame is the context being preempted.
  assign push_data = pop ? top : nest_entry_t'{level: level_q, nest: nest_q};

  always_comb begin
    state_d     = state_q;
    lat_id_d    = lat_id_q;
    lat_level_d = lat_level_q;
    lat_heti_d  = lat_heti_q;
    lat_nest_d  = lat_nest_q;
    level_d     = level_q;
    nest_d      = nest_q;
    ack_d       = 1'b0;
    ack_id_d    = ack_id_q;
    err_d       = err_q;
    push        = 1'b0;

    if (pop) begin
      level_d = top.level;
      nest_d  = top.nest;
    end
    if (ctrl_if.core_mret_i && empty) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      RUN: begin
        if (eligible) begin
          lat_id_d    = ctrl_if.irq_id_i;
          lat_level_d = ctrl_if.irq_level_i;
          lat_heti_d  = ctrl_if.irq_heti_i;
          lat_nest_d  = ctrl_if.irq_nest_i;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (ctrl_if.core_irq_ack_i) begin
          push     = 1'b1;
          level_d  = lat_nest_q ? lat_level_q : PrioWidth'(NrIrqPrios - 1);
          nest_d   = lat_nest_q;
          ack_d    = 1'b1;
          ack_id_d = lat_id_q;
          state_d  = RUN;
        end else if (eligible && (ctrl_if.irq_level_i > lat_level_q)) begin
          lat_id_d    = ctrl_if.irq_id_i;
          lat_level_d = ctrl_if.irq_level_i;
          lat_heti_d  = ctrl_if.irq_heti_i;
          lat_nest_d  = ctrl_if.irq_nest_i;
        end else if (!ctrl_if.irq_valid_i || (lat_level_q <= level_q) || full) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      lat_id_q    <= '0;
      lat_level_q <= '0;
      lat_heti_q  <= 1'b0;
      lat_nest_q  <= 1'b0;
      level_q     <= '0;
      nest_q      <= 1'b0;
      ack_q       <= 1'b0;
      ack_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_id_q    <= lat_id_d;
      lat_level_q <= lat_level_d;
      lat_heti_q  <= lat_heti_d;
      lat_nest_q  <= lat_nest_d;
      level_q     <= level_d;
      nest_q      <= nest_d;
      ack_q       <= ack_d;
      ack_id_q    <= ack_id_d;
      err_q       <= err_d;
    end
  end

  assign ctrl_if.core_irq_req_o  = (state_q == REQ);
  assign ctrl_if.core_irq_id_o   = lat_id_q;
  assign ctrl_if.core_irq_heti_o = lat_heti_q;
  assign ctrl_if.irq_ack_o       = ack_q;
  assign ctrl_if.irq_ack_id_o    = ack_id_q;
  assign level_o                 = level_q;
  assign err_o                   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hetic_nest_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hetic_nest_ctrl : directed self-checking bench for hetic_nest_ctrl
// Rev 1.0
// ============================================================================
module tb_hetic_nest_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] level;
  logic [3:0] depth;
  logic       err;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  hetic_nest_ctrl_if #(.IrqWidth(6), .PrioWidth(5)) bus ();

  hetic_nest_ctrl #(
    .NrIrqLines (64),
    .NrIrqPrios (32),
    .StackDepth (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ctrl_if (bus),
    .level_o (level),
    .depth_o (depth),
    .err_o   (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int id, input int lv, input logic heti, input logic nest);
    bus.irq_valid_i = v;
    bus.irq_id_i    = 6'(id);
    bus.irq_level_i = 5'(lv);
    bus.irq_heti_i  = heti;
    bus.irq_nest_i  = nest;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    bus.core_irq_ack_i = 1'b0;
    bus.core_mret_i    = 1'b0;
    tick();
    tick();
    chk("rst_req",   bus.core_irq_req_o, 0);
    chk("rst_ack",   bus.irq_ack_o, 0);
    chk("rst_level", level, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err",   err, 0);
    rst_n = 1'b1;
    tick();

    // First take: request one cycle after the latch, then claim pulse.
    drive(1'b1, 5, 3, 1'b1, 1'b1);
    tick();
    chk("t1_req",  bus.core_irq_req_o, 1);
    chk("t1_id",   bus.core_irq_id_o, 5);
    chk("t1_heti", bus.core_irq_heti_o, 1);
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    chk("t1_ack",    bus.irq_ack_o, 1);
    chk("t1_ack_id", bus.irq_ack_id_o, 5);
    chk("t1_level",  level, 3);
    chk("t1_depth",  depth, 1);
    chk("t1_reqoff", bus.core_irq_req_o, 0);
    tick();
    chk("t1_stale_req", bus.core_irq_req_o, 0);
    chk("t1_ack_pulse", bus.irq_ack_o, 0);

    // Lower level blocked, higher level nests.
    drive(1'b1, 9, 2, 1'b0, 1'b1);
    tick();
    tick();
    chk("t2_low_req", bus.core_irq_req_o, 0);
    drive(1'b1, 9, 7, 1'b0, 1'b1);
    tick();
    chk("t2_req", bus.core_irq_req_o, 1);
    chk("t2_id",  bus.core_irq_id_o, 9);
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("t2_level", level, 7);
    chk("t2_depth", depth, 2);
    bus.core_mret_i = 1'b1;
    tick();
    chk("t2_mret1_level", level, 3);
    tick();
    bus.core_mret_i = 1'b0;
    chk("t2_mret2_level", level, 0);
    chk("t2_mret2_depth", depth, 0);
    chk("t2_err", err, 0);

    // Non-nesting interrupt raises threshold to the top level.
    drive(1'b1, 4, 4, 1'b0, 1'b0);
    tick();
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    chk("t3_level", level, 31);
    drive(1'b1, 2, 30, 1'b0, 1'b1);
    tick();
    tick();
    chk("t3_blocked", bus.core_irq_req_o, 0);
    bus.core_mret_i = 1'b1;
    tick();
    bus.core_mret_i = 1'b0;
    chk("t3_mret_level", level, 0);
    tick();
    chk("t3_req", bus.core_irq_req_o, 1);
    chk("t3_id",  bus.core_irq_id_o, 2);
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("t3_level30", level, 30);
    bus.core_mret_i = 1'b1;
    tick();
    bus.core_mret_i = 1'b0;

    // Late-arrival upgrade while the core has not acked.
    drive(1'b1, 10, 5, 1'b0, 1'b1);
    tick();
    chk("t4_id10", bus.core_irq_id_o, 10);
    drive(1'b1, 11, 6, 1'b1, 1'b1);
    tick();
    chk("t4_req",  bus.core_irq_req_o, 1);
    chk("t4_id11", bus.core_irq_id_o, 11);
    chk("t4_heti", bus.core_irq_heti_o, 1);
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("t4_ack_id", bus.irq_ack_id_o, 11);
    chk("t4_level",  level, 6);
    bus.core_mret_i = 1'b1;
    tick();
    bus.core_mret_i = 1'b0;
    chk("t4_depth0", depth, 0);

    // Withdraw when the controller drops valid.
    drive(1'b1, 3, 2, 1'b0, 1'b1);
    tick();
    chk("t4w_req", bus.core_irq_req_o, 1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("t4w_withdraw", bus.core_irq_req_o, 0);

    // Fill the stack, then overflow the mret count.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k, k, 1'b0, 1'b1);
      tick();
      bus.core_irq_ack_i = 1'b1;
      tick();
      bus.core_irq_ack_i = 1'b0;
    end
    chk("t5_depth8", depth, 8);
    chk("t5_level8", level, 8);
    drive(1'b1, 9, 9, 1'b0, 1'b1);
    tick();
    tick();
    chk("t5_full_req", bus.core_irq_req_o, 0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    bus.core_mret_i = 1'b1;
    repeat (8) tick();
    chk("t5_depth0", depth, 0);
    chk("t5_level0", level, 0);
    chk("t5_err0",   err, 0);
    tick();
    bus.core_mret_i = 1'b0;
    chk("t5_err1", err, 1);
    tick();
    chk("t5_err_sticky", err, 1);

    // mret and ack in the same cycle at depth 2.
    drive(1'b1, 20, 2, 1'b0, 1'b1);
    tick();
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    drive(1'b1, 21, 4, 1'b0, 1'b1);
    tick();
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    chk("t6_depth2", depth, 2);
    drive(1'b1, 22, 6, 1'b0, 1'b1);
    tick();
    bus.core_irq_ack_i = 1'b1;
    bus.core_mret_i    = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    bus.core_mret_i    = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("t6_depth",  depth, 2);
    chk("t6_level",  level, 6);
    chk("t6_ack_id", bus.irq_ack_id_o, 22);
    bus.core_mret_i = 1'b1;
    tick();
    chk("t6_pop_level", level, 2);
    chk("t6_pop_depth", depth, 1);
    tick();
    bus.core_mret_i = 1'b0;
    chk("t6_pop2_level", level, 0);

    // Asynchronous reset while a request is held.
    drive(1'b1, 7, 3, 1'b0, 1'b1);
    tick();
    bus.core_irq_ack_i = 1'b1;
    tick();
    bus.core_irq_ack_i = 1'b0;
    drive(1'b1, 8, 5, 1'b1, 1'b1);
    tick();
    chk("t7_req", bus.core_irq_req_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req",    bus.core_irq_req_o, 0);
    chk("t7_rst_id",     bus.core_irq_id_o, 0);
    chk("t7_rst_heti",   bus.core_irq_heti_o, 0);
    chk("t7_rst_ack_id", bus.irq_ack_id_o, 0);
    chk("t7_rst_level",  level, 0);
    chk("t7_rst_depth",  depth, 0);
    chk("t7_rst_err",    err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
